// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings, widths and helpers for the divider
package div_pkg;

  // Datapath widths
  localparam int REG_W   = 32;
  localparam int DREG_W  = 64;
  localparam int CNT_W   = 6;
  localparam int WORK_W  = 2 * REG_W + 1;

  // Number of shift-subtract steps for a full quotient
  localparam logic [CNT_W-1:0] STEP_LAST = 6'd32;

  // Control levels
  localparam logic RST_ENABLE       = 1'b1;
  localparam logic DIV_RES_READY    = 1'b1;
  localparam logic DIV_RES_NO_READY = 1'b0;
  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;

  localparam logic [REG_W-1:0]  ZERO_WORD   = '0;
  localparam logic [DREG_W-1:0] ZERO_DWORD  = '0;

  // Divider control states
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Conditional two's-complement negation
  function automatic logic [REG_W-1:0] neg_if(input logic [REG_W-1:0] v,
                                              input logic           c);
    return c ? (~v + 32'd1) : v;
  endfunction

  // Magnitude of an operand when the operation is signed, raw bits otherwise
  function automatic logic [REG_W-1:0] mag_of(input logic [REG_W-1:0] v,
                                              input logic           sgn);
    return neg_if(v, sgn & v[REG_W-1]);
  endfunction

endpackage

// File: rtl/div.sv
// rtl/div.sv - multi-cycle restoring divider, signed and unsigned, with annul
module div
  import div_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              signed_div_i,
  input  logic [REG_W-1:0]  opdata1_i,
  input  logic [REG_W-1:0]  opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [DREG_W-1:0] result_o,
  output logic              ready_o
);

  div_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  // Pre-shifted working register: [64:33] partial remainder, [32:1] pending
  // dividend bits, quotient bits enter at [0]. After 32 steps the remainder
  // sits in [64:33] and the quotient in [31:0].
  logic [WORK_W-1:0]   r_work;
  logic [REG_W-1:0]    r_divisor;
  logic                r_neg_quo;
  logic                r_neg_rem;
  logic [DREG_W-1:0]   r_result;
  logic                r_ready;

  logic [REG_W:0]      w_partial;
  logic [REG_W:0]      w_diff;
  logic                w_fits;
  logic [REG_W-1:0]    w_rem_next;
  logic [WORK_W-1:0]   w_work_next;
  logic [REG_W-1:0]    w_quo_fix;
  logic [REG_W-1:0]    w_rem_fix;
  logic                w_go;

  // Trial subtraction of the divisor from the shifted partial remainder
  assign w_partial   = r_work[WORK_W-1:REG_W];
  assign w_diff      = w_partial - {1'b0, r_divisor};
  assign w_fits      = ~w_diff[REG_W];
  assign w_rem_next  = w_fits ? w_diff[REG_W-1:0] : w_partial[REG_W-1:0];
  assign w_work_next = {w_rem_next, r_work[REG_W-1:0], w_fits};

  // Sign restoration of the unsigned magnitudes
  assign w_quo_fix = neg_if(r_work[REG_W-1:0], r_neg_quo);
  assign w_rem_fix = neg_if(r_work[WORK_W-1:REG_W+1], r_neg_rem);

  assign w_go = (start_i == DIV_START) && !annul_i;

  // Control FSM with datapath and registered result/ready
  always_ff @(posedge Clk) begin
    if (Rst_n == RST_ENABLE) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= ZERO_WORD;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= ZERO_DWORD;
      r_ready   <= DIV_RES_NO_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          r_ready  <= DIV_RES_NO_READY;
          r_result <= ZERO_DWORD;
          if (w_go) begin
            if (opdata2_i == ZERO_WORD) begin
              r_state <= DIV_BY_ZERO;
            end else begin
              r_state   <= DIV_ON;
              r_cnt     <= '0;
              r_work    <= {ZERO_WORD, mag_of(opdata1_i, signed_div_i), 1'b0};
              r_divisor <= mag_of(opdata2_i, signed_div_i);
              r_neg_quo <= signed_div_i & (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
              r_neg_rem <= signed_div_i & opdata1_i[REG_W-1];
            end
          end
        end

        DIV_BY_ZERO: begin
          r_result <= ZERO_DWORD;
          if (annul_i) begin
            r_state <= DIV_FREE;
            r_ready <= DIV_RES_NO_READY;
          end else begin
            r_state <= DIV_END;
            r_ready <= DIV_RES_READY;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_result <= ZERO_DWORD;
            r_ready  <= DIV_RES_NO_READY;
          end else if (r_cnt != STEP_LAST) begin
            r_work <= w_work_next;
            r_cnt  <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= DIV_RES_READY;
            r_state  <= DIV_END;
            r_cnt    <= '0;
          end
        end

        DIV_END: begin
          // Annul has no effect here; only the consumer dropping start releases
          if (start_i == DIV_STOP) begin
            r_state  <= DIV_FREE;
            r_ready  <= DIV_RES_NO_READY;
            r_result <= ZERO_DWORD;
          end
        end

        default: begin
          r_state  <= DIV_FREE;
          r_ready  <= DIV_RES_NO_READY;
          r_result <= ZERO_DWORD;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst_n  input  1  synchronous, active-high reset (asserted when Rst_n == `RstEnable); one clock, no other reset.
REQ-003 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
REQ-004 opdata1_i  input  32  dividend; sampled at start.
REQ-005 opdata2_i  input  32  divisor; sampled at start.
REQ-006 start_i  input  1  `DivStart/`DivStop request level from execute stage; held high until result consumed.
REQ-007 annul_i  input  1  abort in-flight division.
REQ-008 result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 ready_o  output  1  `DivResReady when result_o valid, else `DivResNoReady.

Function
REQ-010 States (encodings as define.v macros): DivFree, DivByZero, DivOn, DivEnd; 6-bit iteration counter cnt.
REQ-011 DivFree: start_i=1 and annul_i=0 and opdata2_i==0 -> DivByZero; start_i=1, annul_i=0, opdata2_i!=0 -> DivOn, cnt=0; otherwise stay.
REQ-012 On entry to DivOn, operands are latched; when signed_div_i=1, each negative operand is replaced by its two's-complement magnitude.
REQ-013 DivOn, cnt<32: one restoring shift-subtract step per cycle on a 65-bit working register (partial remainder, quotient), cnt += 1.
REQ-014 DivOn, cnt==32: apply sign fix-up, register result_o, -> DivEnd; ready_o high the following cycle.
REQ-015 Sign fix-up (signed only): quotient negated iff dividend and divisor signs differ; remainder negated iff dividend negative; unsigned: no fix-up.
REQ-016 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0 (no trap, no special case).
REQ-017 Latency: start sampled in DivFree at cycle T -> ready_o=1 from cycle T+34 (nonzero divisor).
REQ-018 DivByZero: result_o=0, -> DivEnd next cycle; ready_o=1 from T+2.
REQ-019 DivEnd: ready_o=1, result_o held stable while start_i=1; start_i=0 -> DivFree, ready_o=0, result_o=0 next cycle.
REQ-020 annul_i=1 in DivOn or DivByZero -> DivFree next cycle, ready_o=0, result_o=0; annul_i ignored in DivEnd.
REQ-021 start_i dropping in DivOn without annul_i does not abort; operand input changes after start are ignored.
REQ-022 ready_o never high outside DivEnd; a new division needs one DivFree cycle with start_i=1.

Reset
REQ-023 Rst_n asserted, from any state including mid-division: state=DivFree, cnt=0, ready_o=`DivResNoReady, result_o=64'h0, working register cleared, next edge.
REQ-024 First division after reset deassertion follows REQ-017 timing exactly.

Structure
REQ-025 State encodings (DivFree, DivByZero, DivOn, DivEnd), `DivResReady/`DivResNoReady, `DivStart/`DivStop live in shared define.v alongside `RstEnable, `ZeroWord, `DoubleRegBus, `RegBus.
REQ-026 Single flat module; 33-bit trial subtractor inline, no sub-module.

Verification
REQ-027 Unsigned 100/7: start at T -> ready_o=1 at T+34, result_o=64'h00000002_0000000E; held until start_i=0, then 0.
REQ-028 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD; signed 7/-2 -> 64'h00000001_FFFFFFFD.
REQ-029 Divisor 0 (any dividend) -> ready_o=1 at T+2, result_o=64'h0.
REQ-030 annul_i pulse at T+10 -> DivFree at T+11, ready_o stays 0; restart 0xFFFFFFFF/0x10 unsigned -> 64'h0000000F_0FFFFFFF.
REQ-031 Rst_n asserted at T+20 of a division -> ready_o=0, result_o=0 next edge; no stale ready afterwards.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000.
